// File: rtl/modulo_updown_counter_if.sv
// ---------------------------------------------------------------------------
// modulo_updown_counter_if
//   Bundles the control and status signals of one modulo up/down counter
//   digit stage.
//
//   master modport (controller / next stage side):
//     drives  mode, count_in, load, load_value,
//             manual_increment, manual_decrement
//     samples out, carry_out, borrow_out, terminal_count
//   slave modport (the counter itself): the mirror image.
//
//   Clock and reset are not part of the bundle; they remain plain ports on
//   the counter module.
// ---------------------------------------------------------------------------
interface modulo_updown_counter_if #(
    parameter int unsigned WIDTH = 6
);
    logic             mode;              // 0 = up, 1 = down
    logic             count_in;          // automatic step enable
    logic             load;              // synchronous load strobe
    logic [WIDTH-1:0] load_value;        // value taken on load
    logic             manual_increment;  // debounced button level
    logic             manual_decrement;  // debounced button level
    logic [WIDTH-1:0] out;               // current count
    logic             carry_out;         // automatic up-wrap pulse
    logic             borrow_out;        // automatic down-wrap pulse
    logic             terminal_count;    // at boundary for current mode

    modport master (
        output mode,
        output count_in,
        output load,
        output load_value,
        output manual_increment,
        output manual_decrement,
        input  out,
        input  carry_out,
        input  borrow_out,
        input  terminal_count
    );

    modport slave (
        input  mode,
        input  count_in,
        input  load,
        input  load_value,
        input  manual_increment,
        input  manual_decrement,
        output out,
        output carry_out,
        output borrow_out,
        output terminal_count
    );
endinterface

// File: rtl/modulo_updown_counter.sv
// ---------------------------------------------------------------------------
// modulo_updown_counter
//   Modulo-MODULO up/down counter for one time-keeping digit (seconds,
//   minutes, hours). Supports run-time direction, synchronous load with
//   clamping, edge-detected manual adjust buttons and separate carry/borrow
//   pulses so that stages can be cascaded (carry/borrow of one stage feeds
//   count_in of the next).
//
//   Parameters:
//     WIDTH   counter width in bits
//     MODULO  count range is 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//
//   Ports:
//     clk      in   rising-edge system clock
//     clear_n  in   asynchronous active-low reset
//     bus      slave modport of modulo_updown_counter_if:
//                mode, count_in, load, load_value,
//                manual_increment, manual_decrement  (inputs)
//                out, carry_out, borrow_out           (registered outputs)
//                terminal_count                       (combinational output)
//
//   One action per clock edge, highest priority first:
//     load > single manual edge > automatic step (count_in) > hold.
// ---------------------------------------------------------------------------
module modulo_updown_counter #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned MODULO = 60
) (
    input  logic                    clk,
    input  logic                    clear_n,
    modulo_updown_counter_if.slave  bus
);

    // ------------------------------------------------------------------
    // Elaboration check of the modulus range
    // ------------------------------------------------------------------
    localparam longint unsigned RANGE = 64'd1 << WIDTH;

    if (MODULO < 2 || longint'(MODULO) > RANGE) begin : g_bad_modulo
        $error("modulo_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    // Highest legal count. All comparisons are made against this value so
    // the MODULO == 2**WIDTH case never depends on natural overflow.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             carry_q;
    logic             carry_next;
    logic             borrow_q;
    logic             borrow_next;
    logic             inc_q;
    logic             dec_q;

    // ------------------------------------------------------------------
    // Button edge detection: a held button produces a single step.
    // ------------------------------------------------------------------
    logic inc_edge;
    logic dec_edge;
    logic manual_step;

    assign inc_edge    = bus.manual_increment & ~inc_q;
    assign dec_edge    = bus.manual_decrement & ~dec_q;
    // Both edges together cancel; they are still consumed by the history
    // flops, and automatic counting proceeds as if neither had occurred.
    assign manual_step = inc_edge ^ dec_edge;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= bus.manual_increment;
            dec_q <= bus.manual_decrement;
        end
    end

    // ------------------------------------------------------------------
    // Modular step helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_up;
    logic [WIDTH-1:0] count_down;
    logic             at_max;
    logic             at_zero;

    assign at_max     = (count_q == MAX_VAL);
    assign at_zero    = (count_q == '0);
    assign count_up   = at_max  ? '0      : count_q + ONE;
    assign count_down = at_zero ? MAX_VAL : count_q - ONE;

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        count_next  = count_q;
        carry_next  = 1'b0;
        borrow_next = 1'b0;

        if (bus.load) begin
            // Out-of-range load values clamp to the top of the range.
            count_next = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;
        end else if (manual_step) begin
            // Setting the time wraps silently; it must not ripple into the
            // next digit stage.
            count_next = inc_edge ? count_up : count_down;
        end else if (bus.count_in) begin
            if (!bus.mode) begin
                count_next = count_up;
                carry_next = at_max;
            end else begin
                count_next  = count_down;
                borrow_next = at_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_next;
            carry_q  <= carry_next;
            borrow_q <= borrow_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out            = count_q;
    assign bus.carry_out      = carry_q;
    assign bus.borrow_out     = borrow_q;
    assign bus.terminal_count = bus.mode ? at_zero : at_max;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_modulo_updown_counter
//   Directed bench for modulo_updown_counter (WIDTH=6, MODULO=60).
//   Two stages are instantiated: "sec" is driven directly, "mins" counts
//   the carry pulses of "sec".
// ---------------------------------------------------------------------------
module tb_modulo_updown_counter;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned MODULO = 60;

    logic clk;
    logic clear_n;

    int total;
    int bad;

    modulo_updown_counter_if #(.WIDTH(WIDTH)) sec_if ();
    modulo_updown_counter_if #(.WIDTH(WIDTH)) min_if ();

    assign min_if.count_in = sec_if.carry_out;

    modulo_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) u_sec (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (sec_if.slave)
    );

    modulo_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) u_min (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (min_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int min_carries;
    int min_returns;
    logic [WIDTH-1:0] min_prev;

    initial begin
        total = 0;
        bad   = 0;

        clear_n                 = 1'b0;
        sec_if.mode             = 1'b0;
        sec_if.count_in         = 1'b0;
        sec_if.load             = 1'b0;
        sec_if.load_value       = '0;
        sec_if.manual_increment = 1'b0;
        sec_if.manual_decrement = 1'b0;
        min_if.mode             = 1'b0;
        min_if.load             = 1'b0;
        min_if.load_value       = '0;
        min_if.manual_increment = 1'b0;
        min_if.manual_decrement = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_out",    sec_if.out, 0);
        chk("rst_carry",  sec_if.carry_out, 0);
        chk("rst_borrow", sec_if.borrow_out, 0);
        chk("rst_tc",     sec_if.terminal_count, 0);

        // ---------------- 1. reset mid-count ----------------
        clear_n         = 1'b1;
        sec_if.count_in = 1'b1;
        step(); chk("cnt_1", sec_if.out, 1);
        step(); chk("cnt_2", sec_if.out, 2);
        step(); chk("cnt_3", sec_if.out, 3);
        clear_n = 1'b0;
        #1;
        chk("async_rst_out",   sec_if.out, 0);
        chk("async_rst_carry", sec_if.carry_out, 0);
        step(); step(); step();
        chk("rst_hold_out", sec_if.out, 0);
        clear_n = 1'b1;
        step(); chk("rel_1", sec_if.out, 1);
        step(); chk("rel_2", sec_if.out, 2);
        step(); chk("rel_3", sec_if.out, 3);

        // ---------------- 2. up wrap ----------------
        sec_if.load       = 1'b1;
        sec_if.load_value = 6'd57;
        sec_if.count_in   = 1'b0;
        step(); chk("up_load57", sec_if.out, 57);
        chk("up_tc57", sec_if.terminal_count, 0);
        sec_if.load     = 1'b0;
        sec_if.count_in = 1'b1;
        step(); chk("up_58", sec_if.out, 58); chk("up_58_carry", sec_if.carry_out, 0);
        step(); chk("up_59", sec_if.out, 59); chk("up_59_carry", sec_if.carry_out, 0);
        chk("up_59_tc", sec_if.terminal_count, 1);
        step(); chk("up_0", sec_if.out, 0); chk("up_0_carry", sec_if.carry_out, 1);
        chk("up_0_tc", sec_if.terminal_count, 0);
        step(); chk("up_1", sec_if.out, 1); chk("up_1_carry", sec_if.carry_out, 0);

        // ---------------- 3. down wrap ----------------
        sec_if.load       = 1'b1;
        sec_if.load_value = 6'd1;
        step(); chk("dn_load1", sec_if.out, 1);
        sec_if.load = 1'b0;
        sec_if.mode = 1'b1;
        step(); chk("dn_0", sec_if.out, 0); chk("dn_0_borrow", sec_if.borrow_out, 0);
        chk("dn_0_tc", sec_if.terminal_count, 1);
        step(); chk("dn_59", sec_if.out, 59); chk("dn_59_borrow", sec_if.borrow_out, 1);
        chk("dn_59_carry", sec_if.carry_out, 0);
        step(); chk("dn_58", sec_if.out, 58); chk("dn_58_borrow", sec_if.borrow_out, 0);

        // ---------------- load clamp boundaries ----------------
        sec_if.count_in   = 1'b0;
        sec_if.mode       = 1'b0;
        sec_if.load       = 1'b1;
        sec_if.load_value = 6'd60;
        step(); chk("clamp_60", sec_if.out, 59);
        sec_if.load_value = 6'd0;
        step(); chk("load_0", sec_if.out, 0);

        // mode change at boundary produces no pulse
        sec_if.load = 1'b0;
        sec_if.mode = 1'b1;
        #1; chk("mode_tc_dn", sec_if.terminal_count, 1);
        step(); chk("mode_chg_borrow", sec_if.borrow_out, 0);
        chk("mode_chg_out", sec_if.out, 0);

        // ---------------- 4. manual adjust ----------------
        sec_if.mode       = 1'b0;
        sec_if.load       = 1'b1;
        sec_if.load_value = 6'd59;
        step(); chk("man_load59", sec_if.out, 59);
        sec_if.load             = 1'b0;
        sec_if.manual_increment = 1'b1;
        step(); chk("man_inc_wrap", sec_if.out, 0);
        chk("man_inc_carry", sec_if.carry_out, 0);
        repeat (9) step();
        chk("man_inc_held", sec_if.out, 0);
        chk("man_held_carry", sec_if.carry_out, 0);
        sec_if.manual_increment = 1'b0;
        step();
        sec_if.manual_decrement = 1'b1;
        step(); chk("man_dec_wrap", sec_if.out, 59);
        chk("man_dec_borrow", sec_if.borrow_out, 0);
        sec_if.manual_decrement = 1'b0;
        step(); chk("man_dec_rel", sec_if.out, 59);
        sec_if.manual_increment = 1'b1;
        sec_if.manual_decrement = 1'b1;
        step(); chk("man_both", sec_if.out, 59);
        sec_if.manual_increment = 1'b0;
        sec_if.manual_decrement = 1'b0;
        step();

        // ---------------- 5. priority ----------------
        sec_if.load             = 1'b1;
        sec_if.load_value       = 6'd63;
        sec_if.manual_increment = 1'b1;
        sec_if.count_in         = 1'b1;
        step(); chk("pri_load_clamp", sec_if.out, 59);
        chk("pri_load_carry", sec_if.carry_out, 0);
        sec_if.load             = 1'b0;
        sec_if.manual_increment = 1'b0;
        sec_if.count_in         = 1'b0;
        step(); chk("pri_idle", sec_if.out, 59);
        sec_if.manual_increment = 1'b1;
        sec_if.count_in         = 1'b1;
        step(); chk("pri_manual_out", sec_if.out, 0);
        chk("pri_manual_carry", sec_if.carry_out, 0);
        sec_if.manual_increment = 1'b0;
        sec_if.count_in         = 1'b0;

        // ---------------- 6. cascade ----------------
        clear_n = 1'b0;
        step();
        chk("cas_rst_min", min_if.out, 0);
        clear_n         = 1'b1;
        sec_if.count_in = 1'b1;
        min_carries     = 0;
        min_returns     = 0;
        min_prev        = min_if.out;
        for (int i = 1; i <= 3603; i++) begin
            if (i == 3601) sec_if.count_in = 1'b0;
            step();
            if (min_if.carry_out === 1'b1) min_carries++;
            if (min_if.out == '0 && min_prev != '0) min_returns++;
            min_prev = min_if.out;
            if (i == 61) chk("cas_min_61", min_if.out, 1);
        end
        chk("cas_sec_end",     sec_if.out, 0);
        chk("cas_min_end",     min_if.out, 0);
        chk("cas_min_returns", min_returns, 1);
        chk("cas_min_carries", min_carries, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
